// File: rtl/serial_alu_seq_pkg.sv
// serial_alu_seq_pkg: shared opcodes, FSM state encodings and helpers for the bit-serial ALU.
// Revision 1.0
`default_nettype none

package serial_alu_seq_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_NOTA = 3'b010;
   localparam logic [2:0] ALU_NOTB = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_ORN  = 3'b101;
   localparam logic [2:0] ALU_AND  = 3'b110;
   localparam logic [2:0] ALU_ANDN = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op[2:1] == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: start/busy/done handshake and operand/result bus (ovf present with SERIAL_ALU_OVF_EN).
// Revision 1.0
`default_nettype none

interface serial_alu_seq_if #(
   parameter int WIDTH = 16
) ();

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zero;
`ifdef SERIAL_ALU_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, op, a, b,
      input  busy, done, result, cout, zero
`ifdef SERIAL_ALU_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout, zero
`ifdef SERIAL_ALU_OVF_EN
      , output ovf
`endif
   );

endinterface

`default_nettype wire

// File: rtl/ALUslice.sv
// ALUslice: 1-bit ALU slice; full adder with optional B inversion plus the logic functions.
// Revision 1.0
`default_nettype none

module ALUslice
   import serial_alu_seq_pkg::*;
(
   input  logic [2:0] c,
   input  logic       ai,
   input  logic       bi,
   input  logic       ci,
   output logic       f,
   output logic       co
);

   logic bx;

   // Carry chain always runs on (a, b or ~b) so logic ops still produce a co.
   assign bx = c[0] ? ~bi : bi;
   assign co = (ai & bx) | (ci & (ai ^ bx));

   always_comb begin
      f = 1'b0;
      case (c)
         ALU_ADD,
         ALU_SUB:  f = ai ^ bx ^ ci;
         ALU_NOTA: f = ~ai;
         ALU_NOTB: f = ~bi;
         ALU_OR:   f = ai | bi;
         ALU_ORN:  f = ai | ~bi;
         ALU_AND:  f = ai & bi;
         ALU_ANDN: f = ai & ~bi;
         default:  f = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial WIDTH-bit ALU sequencing one ALUslice LSB-first; SERIAL_ALU_OVF_EN adds ovf.
// Revision 1.0
`default_nettype none

module serial_alu_seq
   import serial_alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   serial_alu_seq_if.slave    bus
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, res_sh_d, result_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, zero_q;
   logic             slice_f, slice_co;
   logic             accept, last_bit;

   ALUslice u_slice (
      .c  (op_q),
      .ai (a_sh_q[0]),
      .bi (b_sh_q[0]),
      .ci (carry_q),
      .f  (slice_f),
      .co (slice_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      last_bit = 1'b0;
      res_sh_d = {slice_f, res_sh_q[WIDTH-1:1]};
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST_BIT) begin
               last_bit = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (accept) begin
         a_sh_q   <= bus.a;
         b_sh_q   <= bus.b;
         op_q     <= bus.op;
         cnt_q    <= '0;
         res_sh_q <= '0;
         // Subtract is a + ~b + 1: the +1 enters as the initial carry.
         carry_q  <= (bus.op == ALU_SUB);
      end else if (state_q == S_RUN) begin
         a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
         b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
         res_sh_q <= res_sh_d;
         carry_q  <= slice_co;
         cnt_q    <= cnt_q + CW'(1);
         if (last_bit) begin
            result_q <= res_sh_d;
            cout_q   <= op_is_arith(op_q) ? slice_co : 1'b0;
            zero_q   <= (res_sh_d == '0);
         end
      end
   end

`ifdef SERIAL_ALU_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            ovf_q <= 1'b0;
      else if (state_q == S_RUN && last_bit) ovf_q <= op_is_arith(op_q) ? (carry_q ^ slice_co) : 1'b0;
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy   = (state_q == S_RUN);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed and random operations against an arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_serial_alu_seq;
   import serial_alu_seq_pkg::*;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

   serial_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {ovf, cout, result} computed directly from the operation definitions.
   function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0];
            c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         3'd2: r = ~a;
         3'd3: r = ~b;
         3'd4: r = a | b;
         3'd5: r = a | ~b;
         3'd6: r = a & b;
         default: r = a & ~b;
      endcase
      return {v, c, r};
   endfunction

   task automatic check_result(input string tag, input logic [17:0] m);
      check_val({tag, "_result"}, 32'(bus.result), 32'(m[15:0]));
      check_val({tag, "_cout"},   32'(bus.cout),   32'(m[16]));
      check_val({tag, "_zero"},   32'(bus.zero),   32'(m[15:0] == 16'h0));
`ifdef SERIAL_ALU_OVF_EN
      check_val({tag, "_ovf"},    32'(bus.ovf),    32'(m[17]));
`endif
   endtask

   // Called #1 after an edge with the DUT idle; start is accepted on the next edge.
   task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input bit noisy);
      logic [17:0] m;
      m = model(op, a, b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= WIDTH; k++) begin
         @(posedge clk); #1;
         if (k < WIDTH) begin
            check_val("busy_run", 32'({bus.busy, bus.done}), 32'(2'b10));
            if (noisy) begin
               bus.start = 1'($urandom_range(0, 1));
               bus.a     = 16'($urandom);
               bus.b     = 16'($urandom);
               bus.op    = 3'($urandom);
            end
         end
      end
      check_val("done_pulse", 32'({bus.busy, bus.done}), 32'(2'b01));
      check_result("op", m);
      if (noisy) bus.start = 1'b1;
      @(posedge clk); #1;
      check_val("idle_after", 32'({bus.busy, bus.done}), 32'(2'b00));
      check_val("held_result", 32'(bus.result), 32'(m[15:0]));
      bus.start = 1'b0;
   endtask

   initial begin
      logic [17:0] m;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;

      @(posedge clk); #1;
      check_val("rst_state", 32'({bus.busy, bus.done, bus.cout, bus.zero}), 32'(0));
      check_val("rst_result", 32'(bus.result), 32'(0));
`ifdef SERIAL_ALU_OVF_EN
      check_val("rst_ovf", 32'(bus.ovf), 32'(0));
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(ALU_ADD,  16'h0005, 16'h0003, 1'b0);
      run_op(ALU_SUB,  16'h0003, 16'h0003, 1'b0);
      run_op(ALU_SUB,  16'h0002, 16'h0005, 1'b0);
      run_op(ALU_ADD,  16'hFFFF, 16'h0001, 1'b0);
      run_op(ALU_ADD,  16'h7FFF, 16'h0001, 1'b0);
      run_op(ALU_SUB,  16'h8000, 16'h0001, 1'b0);
      run_op(ALU_NOTA, 16'h1234, 16'h5A5A, 1'b0);
      run_op(ALU_NOTB, 16'h1234, 16'h5A5A, 1'b0);
      run_op(ALU_ANDN, 16'hF0F0, 16'hFF00, 1'b0);
      run_op(ALU_ORN,  16'h0000, 16'hFFFF, 1'b0);
      run_op(ALU_OR,   16'h0F00, 16'h00F0, 1'b1);
      run_op(ALU_AND,  16'hFFFF, 16'h8001, 1'b1);

      for (int i = 0; i < 40; i++)
         run_op(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

      // start held high: a fresh accept every WIDTH+2 edges.
      m = model(ALU_ADD, 16'h1111, 16'h2222);
      bus.start = 1'b1;
      bus.op    = ALU_ADD;
      bus.a     = 16'h1111;
      bus.b     = 16'h2222;
      @(posedge clk); #1;
      for (int k = 1; k <= 2 * WIDTH + 4; k++) begin
         @(posedge clk); #1;
         check_val("held_start",
                   32'({bus.busy, bus.done}),
                   32'({((k >= 1 && k <= WIDTH - 1) || (k >= WIDTH + 2 && k <= 2 * WIDTH + 1)),
                        (k == WIDTH || k == 2 * WIDTH + 2)}));
         if (k == 2 * WIDTH + 2) check_result("held_start", m);
         if (k == 2 * WIDTH + 3) bus.start = 1'b0;
      end

      // Asynchronous reset in the middle of a run.
      run_op(ALU_ADD, 16'hFFFF, 16'hFFFF, 1'b0);
      bus.start = 1'b1;
      bus.op    = ALU_ADD;
      bus.a     = 16'h1234;
      bus.b     = 16'h1111;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_val("async_rst_flags", 32'({bus.busy, bus.done, bus.cout, bus.zero}), 32'(0));
      check_val("async_rst_result", 32'(bus.result), 32'(0));
`ifdef SERIAL_ALU_OVF_EN
      check_val("async_rst_ovf", 32'(bus.ovf), 32'(0));
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(ALU_ADD, 16'h0001, 16'h0001, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
